// File: rtl/peripheral_req2axi4_master.sv
// Single-outstanding AXI4 master: turns one valid/ready request into a single-beat
// AXI4 write or read, with a watchdog that aborts transactions the slave stalls.
module peripheral_req2axi4_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] awadr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wrdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_d;
    logic [7:0]  wd_cnt, wd_cnt_d;
    logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic        rsp_valid_d, rsp_err_d;
    logic [31:0] awadr_d, wrdata_d, araddr_d, rsp_rdata_d;
    logic [3:0]  wstrb_d;
    logic        any_hs, timeout;
    logic        unused_resp;

    // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp = bresp[0] ^ rresp[0];

    assign req_ready = (state == IDLE);
    assign wlast     = wvalid;

    assign any_hs  = (awvalid && awready) || (wvalid && wready) || (bvalid && bready)
                  || (arvalid && arready) || (rvalid && rready);
    // A handshake landing on the deadline cycle still wins; it restarts the timer.
    assign timeout = (state != IDLE) && (wd_cnt == TIMEOUT_CNT) && !any_hs;

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
        state_d     = state;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        bready_d    = bready;
        arvalid_d   = arvalid;
        rready_d    = rready;
        awadr_d     = awadr;
        wrdata_d    = wrdata;
        wstrb_d     = wstrb;
        araddr_d    = araddr;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        wd_cnt_d    = wd_cnt + 8'd1;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        awadr_d   = req_addr;
                        wrdata_d  = req_wdata;
                        wstrb_d   = req_strb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WADDR;
                    end else begin
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WADDR: begin
                if (awvalid && awready) awvalid_d = 1'b0;
                if (wvalid && wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (bvalid) begin
                    bready_d    = 1'b0;
                    rsp_err_d   = bresp[1];
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = rresp[1];
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = DONE;
        end

        if ((state == IDLE) || (state_d != state) || any_hs) wd_cnt_d = '0;
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awadr     <= '0;
            wrdata    <= '0;
            wstrb     <= '0;
            araddr    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_d;
            wd_cnt    <= wd_cnt_d;
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            bready    <= bready_d;
            arvalid   <= arvalid_d;
            rready    <= rready_d;
            awadr     <= awadr_d;
            wrdata    <= wrdata_d;
            wstrb     <= wstrb_d;
            araddr    <= araddr_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_peripheral_req2axi4_master.sv
// Bench for peripheral_req2axi4_master: a configurable AXI4 slave with its own memory,
// a word-level reference memory, directed vectors, random traffic and corner sequences.
module tb_peripheral_req2axi4_master;

    localparam int TB_TIMEOUT = 8;

    logic        aclk, aresetn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awadr, wrdata, araddr, rdata;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    peripheral_req2axi4_master #(.TIMEOUT(TB_TIMEOUT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awadr(awadr), .awvalid(awvalid), .awready(awready),
        .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int proto_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          ar_never = 1'b0;
    logic [31:0] s_mem [logic [29:0]];
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    bit          aw_done, w_done, ar_done, b_hs, r_hs;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] st);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
        return w;
    endfunction

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_done = 0; w_done = 0; ar_done = 0; b_hs = 0; r_hs = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (b_hs) begin
                    bvalid = 0; b_hs = 0; aw_done = 0; w_done = 0;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end else if (aw_done && w_done && !bvalid) begin
                    if (b_cnt >= b_dly) begin
                        bvalid = 1; bresp = bresp_cfg;
                        if (bresp_cfg == 2'b00)
                            s_mem[s_awaddr[31:2]] = merge(s_mem.exists(s_awaddr[31:2]) ?
                                s_mem[s_awaddr[31:2]] : 32'h0, s_wdata, s_wstrb);
                    end else b_cnt++;
                end
                if (bvalid && bready) b_hs = 1;

                if (r_hs) begin
                    rvalid = 0; r_hs = 0; ar_done = 0; ar_cnt = 0; r_cnt = 0;
                end else if (ar_done && !rvalid) begin
                    if (r_cnt >= r_dly) begin
                        rvalid = 1; rresp = rresp_cfg;
                        rdata = s_mem.exists(s_araddr[31:2]) ? s_mem[s_araddr[31:2]] : 32'h0;
                    end else r_cnt++;
                end
                if (rvalid && rready) r_hs = 1;

                if (awready) awready = 0;
                else if (awvalid && !aw_done) begin
                    if (aw_cnt >= aw_dly) begin awready = 1; aw_done = 1; s_awaddr = awadr; end
                    else aw_cnt++;
                end
                if (wready) wready = 0;
                else if (wvalid && !w_done) begin
                    if (w_cnt >= w_dly) begin
                        wready = 1; w_done = 1; s_wdata = wrdata; s_wstrb = wstrb;
                    end else w_cnt++;
                end
                if (arready) arready = 0;
                else if (arvalid && !ar_done && !ar_never) begin
                    if (ar_cnt >= ar_dly) begin arready = 1; ar_done = 1; s_araddr = araddr; end
                    else ar_cnt++;
                end
            end
        end
    end

    // Valid/payload must hold until handshake (aborts and resets excepted); wlast tracks wvalid.
    initial begin
        logic p_rstn, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [31:0] p_awadr, p_wd, p_ara;
        logic [3:0]  p_ws;
        p_rstn = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_awadr = 0; p_wd = 0; p_ara = 0; p_ws = 0;
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn && p_rstn && !rsp_valid) begin
                if (p_awv && !p_awr && (!awvalid || awadr !== p_awadr)) proto_bad++;
                if (p_wv && !p_wr && (!wvalid || wrdata !== p_wd || wstrb !== p_ws)) proto_bad++;
                if (p_arv && !p_arr && (!arvalid || araddr !== p_ara)) proto_bad++;
            end
            if (wlast !== wvalid) proto_bad++;
            p_rstn = aresetn; p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
            p_arv = arvalid; p_arr = arready; p_awadr = awadr; p_wd = wrdata; p_ws = wstrb;
            p_ara = araddr;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_mem [logic [29:0]];

    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] st, input logic [1:0] br,
                             output logic [31:0] exp_rd);
        logic [31:0] old;
        old = m_mem.exists(addr[31:2]) ? m_mem[addr[31:2]] : 32'h0;
        exp_rd = we ? 32'h0 : old;
        if (we && br == 2'b00) m_mem[addr[31:2]] = merge(old, wd, st);
    endtask

    task automatic set_slave(input int a, input int w, input int b, input int ar, input int r,
                             input logic [1:0] br, input logic [1:0] rr);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
        bresp_cfg = br; rresp_cfg = rr;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 20 && !req_ready; i++) step();
        step();
    endtask

    task automatic wait_rsp(output logic got);
        got = 0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin got = 1; break; end
            step();
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic er,
                          output logic got);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_strb = st;
        wait_accept();
        req_valid = 0;
        wait_rsp(got);
        rd = rsp_rdata; er = rsp_err;
        step();
        check("rsp pulse one cycle", {31'h0, rsp_valid}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  bresp, rresp;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, got;
        int          n, aw_hs, w_hs, first_b, aw_late, held_bad, wv_cycles, rsp_seen;

        vecs[0]  = '{1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 0, 0, 2, 0, 0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,         4'h0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1'b0, 32'hA5A5_1234};
        vecs[2]  = '{1'b1, 32'h14, 32'hDEAD_BEEF, 4'h5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h14, 32'h0,         4'h0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1'b0, 32'h00AD_00EF};
        vecs[4]  = '{1'b1, 32'h10, 32'h1122_3344, 4'h8, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h10, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1'b1, 32'hA5A5_1234};
        vecs[6]  = '{1'b1, 32'h10, 32'h1122_3344, 4'h8, 2, 0, 1, 0, 0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,         4'h0, 0, 0, 0, 3, 2, 2'b00, 2'b00, 1'b0, 32'h11A5_1234};
        vecs[8]  = '{1'b1, 32'h13, 32'h0000_0055, 4'h1, 0, 3, 0, 0, 0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h12, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1'b0, 32'h11A5_1255};
        vecs[10] = '{1'b0, 32'h20, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 32'h20, 32'h7777_7777, 4'hF, 0, 0, 0, 0, 0, 2'b11, 2'b00, 1'b1, 32'h0};

        aresetn = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        repeat (3) step();
        check("reset valids", {24'h0, awvalid, wvalid, wlast, bready, arvalid, rready,
                               rsp_valid, rsp_err}, 32'h0);
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset addr/data", awadr | wrdata | araddr | rsp_rdata | {28'h0, wstrb}, 32'h0);
        aresetn = 1;
        step();

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            set_slave(vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, vecs[i].ar_dly,
                      vecs[i].r_dly, vecs[i].bresp, vecs[i].rresp);
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, got);
            check($sformatf("vec%0d rsp seen", i), {31'h0, got}, 32'h1);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d addr passthrough", i),
                  vecs[i].we ? s_awaddr : s_araddr, vecs[i].addr);
            model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].bresp,
                      exp_rd);
        end

        // wready held off 3 cycles behind awready.
        set_slave(0, 3, 1, 0, 0, 2'b00, 2'b00);
        req_valid = 1; req_we = 1; req_addr = 32'h18; req_wdata = 32'hCAFE_F00D; req_strb = 4'hF;
        wait_accept();
        req_valid = 0;
        aw_hs = -1; w_hs = -1; first_b = -1; aw_late = 0; held_bad = 0; wv_cycles = 0;
        rsp_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) begin rsp_seen = 1; break; end
            if (wvalid) begin
                wv_cycles++;
                if (wrdata !== 32'hCAFE_F00D || wstrb !== 4'hF) held_bad++;
            end
            if (awvalid && aw_hs >= 0) aw_late++;
            if (bready && first_b < 0) first_b = k;
            if (awready && aw_hs < 0) aw_hs = k;
            if (wready && w_hs < 0) w_hs = k;
            step();
        end
        check("wdelay rsp seen", rsp_seen, 1);
        check("wdelay err", {31'h0, rsp_err}, 32'h0);
        check("wdelay w-after-aw gap", w_hs - aw_hs, 3);
        check("wdelay awvalid dropped", aw_late, 0);
        check("wdelay wdata held", held_bad, 0);
        check("wdelay wvalid cycles", wv_cycles, w_hs + 1);
        check("wdelay bready after both", first_b, w_hs + 1);
        step();
        model_txn(1'b1, 32'h18, 32'hCAFE_F00D, 4'hF, 2'b00, exp_rd);

        // Random traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            logic        we;
            logic [31:0] addr, wd;
            logic [3:0]  st;
            logic [1:0]  br, rr;
            we   = 1'($urandom_range(0, 1));
            addr = 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            wd   = $urandom;
            st   = 4'($urandom_range(0, 15));
            br   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rr   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), br, rr);
            model_txn(we, addr, wd, st, br, exp_rd);
            do_req(we, addr, wd, st, rd, er, got);
            check($sformatf("rand%0d rsp seen", t), {31'h0, got}, 32'h1);
            check($sformatf("rand%0d rdata", t), rd, exp_rd);
            check($sformatf("rand%0d err", t), {31'h0, er}, {31'h0, we ? br[1] : rr[1]});
        end

        // Back-to-back: req_valid held high across two reads.
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        req_valid = 1; req_we = 0; req_addr = 32'h10;
        wait_accept();
        wait_rsp(got);
        check("b2b first rsp", {31'h0, got}, 32'h1);
        model_txn(1'b0, 32'h10, 32'h0, 4'h0, 2'b00, exp_rd);
        check("b2b first rdata", rsp_rdata, exp_rd);
        check("b2b not ready in done", {31'h0, req_ready}, 32'h0);
        step();
        check("b2b ready after done", {31'h0, req_ready}, 32'h1);
        req_addr = 32'h14;
        step();
        req_valid = 0;
        check("b2b second accepted", {arvalid, araddr[30:0]}, {1'b1, 31'h14});
        wait_rsp(got);
        model_txn(1'b0, 32'h14, 32'h0, 4'h0, 2'b00, exp_rd);
        check("b2b second rdata", rsp_rdata, exp_rd);
        step();

        // Watchdog: arready never arrives.
        ar_never = 1;
        req_valid = 1; req_we = 0; req_addr = 32'h30;
        wait_accept();
        req_valid = 0;
        check("timeout arvalid rose", {31'h0, arvalid}, 32'h1);
        n = 0;
        rsp_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) begin rsp_seen = 1; break; end
            step();
            n++;
        end
        check("timeout rsp seen", rsp_seen, 1);
        check("timeout latency", n, TB_TIMEOUT + 1);
        check("timeout err", {31'h0, rsp_err}, 32'h1);
        check("timeout rdata", rsp_rdata, 32'h0);
        check("timeout arvalid dropped", {31'h0, arvalid}, 32'h0);
        step();
        ar_never = 0;

        // Reset while waiting for the write response.
        set_slave(0, 0, 5, 0, 0, 2'b00, 2'b00);
        req_valid = 1; req_we = 1; req_addr = 32'h1C; req_wdata = 32'h1234_5678; req_strb = 4'hF;
        wait_accept();
        req_valid = 0;
        for (int k = 0; k < 20 && !bready; k++) step();
        check("reset test reached WRESP", {31'h0, bready}, 32'h1);
        aresetn = 0;
        step();
        check("mid reset bready", {31'h0, bready}, 32'h0);
        check("mid reset req_ready", {31'h0, req_ready}, 32'h1);
        check("mid reset valids", {27'h0, awvalid, wvalid, arvalid, rready, rsp_valid}, 32'h0);
        aresetn = 1;
        rsp_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) rsp_seen++;
            step();
        end
        check("no rsp after reset", rsp_seen, 0);
        model_txn(1'b0, 32'h1C, 32'h0, 4'h0, 2'b00, exp_rd);
        do_req(1'b0, 32'h1C, 32'h0, 4'h0, rd, er, got);
        check("post reset read", rd, exp_rd);

        check("protocol violations", proto_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got expired expected finish");
        $fatal(1);
    end

endmodule
